// File: rtl/banco_pkg.sv
// Shared types and index helpers for the multi-port register bank.
package banco_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int unsigned N_DEF = 5;
  localparam int unsigned W_DEF = 8;
  localparam int unsigned R_DEF = 2;

  // Register count for an address width of n bits.
  function automatic int unsigned nreg(input int unsigned n);
    return 32'(1) << n;
  endfunction

  // Low bit of slice idx in a packed vector of w-bit slices.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/banco_lectura.sv
// One combinational read port: register-0 forcing and optional write bypass.
module banco_lectura
  import banco_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned W      = W_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic [W-1:0] mem [nreg(N)],
  input  logic [N-1:0] addr,
  input  logic [N-1:0] addr_wr,
  input  logic [W-1:0] data_wr,
  input  logic         wr_live,
  output logic [W-1:0] data_c
);

  // Register 0 always reads zero; an in-flight IDLE write to this address forwards when enabled.
  always_comb begin
    data_c = mem[addr];
    if (addr == '0) begin
      data_c = '0;
    end else if ((BYPASS != 0) && wr_live && (addr_wr != '0) && (addr == addr_wr)) begin
      data_c = data_wr;
    end
  end

endmodule

// File: rtl/banco_registro_mp.sv
// Multi-port register file with hardwired zero register and a sequenced bulk-clear engine.
module banco_registro_mp
  import banco_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned W      = W_DEF,
  parameter int unsigned R      = R_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [N-1:0]   addr_rd,
  input  logic [W-1:0]   data_in,
  input  logic [R*N-1:0] addr_rs,
  output logic [R*W-1:0] rs,
  input  logic           clr_req,
  output logic           busy,
  output logic           wr_err
);

  localparam int unsigned NREG = nreg(N);
  localparam logic [N-1:0] LAST = N'(NREG - 1);

  state_t       state;
  logic [N-1:0] cnt;
  logic [W-1:0] mem [NREG];
  logic         wr_live;

  // A write only lands (and may be forwarded) while the clear engine is idle.
  assign wr_live = we && (state == IDLE);

  // Register array, clear sequencer, busy and dropped-write flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      wr_err <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          wr_err <= 1'b0;
          if (we && (addr_rd != '0)) begin
            mem[addr_rd] <= data_in;
          end
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= N'(1);
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          wr_err   <= we;
          mem[cnt] <= '0;
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + N'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // One read port per slice of addr_rs/rs.
  for (genvar k = 0; k < R; k++) begin : g_rd
    localparam int unsigned A_LO = slice_lo(k, N);
    localparam int unsigned D_LO = slice_lo(k, W);
    banco_lectura #(
      .N      (N),
      .W      (W),
      .BYPASS (BYPASS)
    ) u_rd (
      .mem     (mem),
      .addr    (addr_rs[A_LO +: N]),
      .addr_wr (addr_rd),
      .data_wr (data_in),
      .wr_live (wr_live),
      .data_c  (rs[D_LO +: W])
    );
  end

endmodule

// File: tb/tb_banco_registro_mp.sv
// Self-checking bench for banco_registro_mp (N=3, W=8, R=2), bypass and no-bypass instances.
module tb_banco_registro_mp;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  addr_rd;
  logic [7:0]  data_in;
  logic [5:0]  addr_rs;
  logic        clr_req;
  logic [15:0] rs, rs_nb;
  logic        busy, busy_nb, wr_err, wr_err_nb;

  int cmp_count = 0;
  int err_count = 0;

  // Reference model: register contents plus clear progress.
  logic [7:0] model_mem [8];
  bit         m_busy;
  int         m_clear_idx;
  bit         m_wr_err;

  banco_registro_mp #(.N(3), .W(8), .R(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .we(we), .addr_rd(addr_rd), .data_in(data_in),
    .addr_rs(addr_rs), .rs(rs), .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
  );

  banco_registro_mp #(.N(3), .W(8), .R(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .addr_rd(addr_rd), .data_in(data_in),
    .addr_rs(addr_rs), .rs(rs_nb), .clr_req(clr_req), .busy(busy_nb), .wr_err(wr_err_nb)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
    m_busy = 0;
    m_clear_idx = 0;
    m_wr_err = 0;
  endfunction

  // Apply the rules of one rising edge to the model using the current inputs.
  function automatic void model_edge();
    if (!rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (we && addr_rd != 3'd0) model_mem[addr_rd] = data_in;
      m_wr_err = 0;
      if (clr_req) begin
        m_busy = 1;
        m_clear_idx = 1;
      end
    end else begin
      m_wr_err = we;
      model_mem[m_clear_idx] = 8'h00;
      m_clear_idx++;
      if (m_clear_idx == 8) m_busy = 0;
    end
  endfunction

  function automatic logic [7:0] exp_read(input int a, input bit byp);
    if (a == 0) return 8'h00;
    if (byp && !m_busy && we && addr_rd != 3'd0 && a == int'(addr_rd)) return data_in;
    return model_mem[a];
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    we = 0; addr_rd = 3'd0; data_in = 8'h00; clr_req = 0;
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    rst = 0; idle_inputs(); addr_rs = 6'd0;
    model_reset();
    tick(); tick();
    rst = 1;
    @(negedge clk);
    cmp_count++;
    if (busy !== 1'b0 || busy_nb !== 1'b0) begin
      err_count++; $display("FAIL reset_busy got=%b/%b exp=0", busy, busy_nb);
    end
    cmp_count++;
    if (wr_err !== 1'b0 || wr_err_nb !== 1'b0) begin
      err_count++; $display("FAIL reset_wr_err got=%b/%b exp=0", wr_err, wr_err_nb);
    end
    for (int p = 0; p < 4; p++) begin
      addr_rs = {3'(2*p+1), 3'(2*p)}; #1;
      for (int k = 0; k < 2; k++) begin
        got = rs[k*8 +: 8]; exp = 8'h00;
        cmp_count++;
        if (got !== exp) begin
          err_count++; $display("FAIL reset_read addr=%0d got=%h exp=%h", 2*p+k, got, exp);
        end
      end
    end
  endtask

  task automatic test_write_readback();
    logic [7:0] got, exp;
    we = 1; addr_rd = 3'd3; data_in = 8'hA5; tick();
    addr_rd = 3'd5; data_in = 8'h3C; tick();
    idle_inputs();
    addr_rs = {3'd5, 3'd3}; #1;
    cmp_count++;
    if (rs !== {8'h3C, 8'hA5}) begin
      err_count++; $display("FAIL readback got=%h exp=%h", rs, {8'h3C, 8'hA5});
    end
    we = 1; addr_rd = 3'd0; data_in = 8'hFF; tick();
    idle_inputs();
    addr_rs = {3'd0, 3'd0}; #1;
    cmp_count++;
    if (rs !== 16'h0000 || wr_err !== 1'b0) begin
      err_count++; $display("FAIL zero_reg got=%h wr_err=%b exp=0000/0", rs, wr_err);
    end
    // Random writes with random two-port reads each cycle.
    for (int c = 0; c < 60; c++) begin
      we = 1'($urandom_range(0, 1)); addr_rd = 3'($urandom); data_in = 8'($urandom);
      addr_rs = 6'($urandom); #1;
      for (int k = 0; k < 2; k++) begin
        got = rs[k*8 +: 8]; exp = exp_read(int'(addr_rs[k*3 +: 3]), 1'b1);
        cmp_count++;
        if (got !== exp) begin
          err_count++; $display("FAIL rand_rw port=%0d addr=%0d got=%h exp=%h", k, addr_rs[k*3 +: 3], got, exp);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_bypass();
    logic [7:0] old6;
    we = 1; addr_rd = 3'd6; data_in = 8'h33; tick();
    old6 = 8'h33;
    we = 1; addr_rd = 3'd6; data_in = 8'h77; addr_rs = {3'd6, 3'd6}; #1;
    cmp_count++;
    if (rs[7:0] !== 8'h77 || rs[15:8] !== 8'h77) begin
      err_count++; $display("FAIL bypass_on got=%h exp=7777", rs);
    end
    cmp_count++;
    if (rs_nb[7:0] !== old6) begin
      err_count++; $display("FAIL bypass_off got=%h exp=%h", rs_nb[7:0], old6);
    end
    tick();
    idle_inputs(); #1;
    cmp_count++;
    if (rs[7:0] !== 8'h77 || rs_nb[7:0] !== 8'h77) begin
      err_count++; $display("FAIL bypass_after got=%h/%h exp=77", rs[7:0], rs_nb[7:0]);
    end
  endtask

  // Runs a clear with optional dropped write at busy cycle wr_at and clr_req at cycle cr_at.
  task automatic run_clear(input int wr_at, input int cr_at, output int nbusy);
    logic [7:0] got, exp;
    int c;
    for (int a = 1; a < 8; a++) begin
      we = 1; addr_rd = 3'(a); data_in = 8'($urandom_range(1, 255)); tick();
    end
    idle_inputs(); clr_req = 1; tick(); clr_req = 0;
    c = 1; nbusy = 0;
    while (busy === 1'b1 && c <= 20) begin
      nbusy++;
      cmp_count++;
      if (wr_err !== 1'(m_wr_err)) begin
        err_count++; $display("FAIL clear_wr_err cycle=%0d got=%b exp=%b", c, wr_err, m_wr_err);
      end
      we = (c == wr_at); addr_rd = 3'd2; data_in = 8'h11; clr_req = (c == cr_at);
      for (int p = 0; p < 4; p++) begin
        addr_rs = {3'(2*p+1), 3'(2*p)}; #1;
        for (int k = 0; k < 2; k++) begin
          got = rs[k*8 +: 8]; exp = exp_read(2*p+k, 1'b1);
          cmp_count++;
          if (got !== exp) begin
            err_count++; $display("FAIL clear_read cycle=%0d addr=%0d got=%h exp=%h", c, 2*p+k, got, exp);
          end
        end
      end
      tick();
      c++;
    end
    idle_inputs();
    cmp_count++;
    if (busy !== 1'(m_busy) || c > 20) begin
      err_count++; $display("FAIL clear_end busy=%b exp=%b cycles=%0d", busy, m_busy, c);
    end
    cmp_count++;
    if (wr_err !== 1'(m_wr_err)) begin
      err_count++; $display("FAIL clear_end_wr_err got=%b exp=%b", wr_err, m_wr_err);
    end
    for (int p = 0; p < 4; p++) begin
      addr_rs = {3'(2*p+1), 3'(2*p)}; #1;
      cmp_count++;
      if (rs !== 16'h0000) begin
        err_count++; $display("FAIL clear_post addr=%0d/%0d got=%h exp=0000", 2*p, 2*p+1, rs);
      end
    end
  endtask

  task automatic test_bulk_clear();
    int nb;
    run_clear(0, 0, nb);
    cmp_count++;
    if (nb != 7) begin
      err_count++; $display("FAIL clear_len got=%0d exp=7", nb);
    end
  endtask

  task automatic test_write_during_clear();
    int nb;
    run_clear(3, 4, nb);
    cmp_count++;
    if (nb != 7) begin
      err_count++; $display("FAIL clear_len_wr got=%0d exp=7", nb);
    end
    run_clear(7, 0, nb);
    cmp_count++;
    if (nb != 7) begin
      err_count++; $display("FAIL clear_len_last got=%0d exp=7", nb);
    end
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 1; a < 8; a++) begin
      we = 1; addr_rd = 3'(a); data_in = 8'(a * 16 + 1); tick();
    end
    idle_inputs(); clr_req = 1; tick(); clr_req = 0;
    tick(); tick();
    rst = 0; #1;
    model_reset();
    cmp_count++;
    if (busy !== 1'b0) begin
      err_count++; $display("FAIL midrst_busy got=%b exp=0", busy);
    end
    for (int p = 0; p < 4; p++) begin
      addr_rs = {3'(2*p+1), 3'(2*p)}; #1;
      cmp_count++;
      if (rs !== 16'h0000) begin
        err_count++; $display("FAIL midrst_read addr=%0d/%0d got=%h exp=0000", 2*p, 2*p+1, rs);
      end
    end
    tick();
    rst = 1;
    we = 1; addr_rd = 3'd4; data_in = 8'h5A; tick();
    idle_inputs(); addr_rs = {3'd0, 3'd4}; #1;
    cmp_count++;
    if (rs[7:0] !== 8'h5A || busy !== 1'b0) begin
      err_count++; $display("FAIL midrst_write got=%h busy=%b exp=5a/0", rs[7:0], busy);
    end
  endtask

  task automatic test_random_mix();
    logic [7:0] got, exp;
    for (int c = 0; c < 300; c++) begin
      we = 1'($urandom_range(0, 1)); addr_rd = 3'($urandom); data_in = 8'($urandom);
      clr_req = ($urandom_range(0, 24) == 0); addr_rs = 6'($urandom); #1;
      cmp_count++;
      if (busy !== 1'(m_busy) || wr_err !== 1'(m_wr_err)) begin
        err_count++; $display("FAIL mix_flags cycle=%0d got=%b%b exp=%b%b", c, busy, wr_err, m_busy, m_wr_err);
      end
      for (int k = 0; k < 2; k++) begin
        got = rs[k*8 +: 8]; exp = exp_read(int'(addr_rs[k*3 +: 3]), 1'b1);
        cmp_count++;
        if (got !== exp) begin
          err_count++; $display("FAIL mix_read cycle=%0d port=%0d got=%h exp=%h", c, k, got, exp);
        end
        got = rs_nb[k*8 +: 8]; exp = exp_read(int'(addr_rs[k*3 +: 3]), 1'b0);
        cmp_count++;
        if (got !== exp) begin
          err_count++; $display("FAIL mix_read_nb cycle=%0d port=%0d got=%h exp=%h", c, k, got, exp);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_bypass();
    test_bulk_clear();
    test_write_during_clear();
    test_reset_mid_clear();
    test_random_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
